// File: rtl/tile_renderer.sv
// tile_renderer
// -------------
// Turns the 80x60 background tile map into per-pixel RGB for the VGA path.
// During horizontal blank one tile row (80 tile numbers) is fetched from the
// map into the inactive half of a ping-pong line buffer. The active half is
// rendered as procedural 8x8 tile art through a two-stage pixel pipeline.
//
// Ports
//   Clk, Reset_h        clock, asynchronous active-high reset
//   Gen_Done            map contents valid while high; falling edge aborts
//   DrawX, DrawY        current scan position
//   MapRd/MapCol/MapRow map read port; tilenumber returns one Clk later
//   Red/Green/Blue      pixel colour, two Clks behind DrawX/DrawY
//   Pixel_Valid         colour belongs to an active-area pixel
//   Underrun            sticky: a bank swap hit an unfinished prefetch
//
// Optional feature
//   TILE_RENDER_GRID_EN  halve every colour channel on tile-local x==0 or
//                        y==0, drawing a faint grid; no added latency.
module tile_renderer #(
    parameter logic [9:0] H_ACTIVE = 10'd640,
    parameter logic [9:0] V_ACTIVE = 10'd480,
    parameter logic [9:0] V_TOTAL  = 10'd525,
    parameter logic [6:0] COLS     = 7'd80
) (
    input  logic       Clk,
    input  logic       Reset_h,
    input  logic       Gen_Done,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       MapRd,
    output logic [6:0] MapCol,
    output logic [5:0] MapRow,
    input  logic [2:0] tilenumber,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue,
    output logic       Pixel_Valid,
    output logic       Underrun
);

    localparam logic [6:0] LAST_COL  = COLS - 7'd1;
    localparam logic [9:0] LAST_LINE = V_TOTAL - 10'd1;
    localparam logic [9:0] LAST_ROW  = V_ACTIVE - 10'd1;

    typedef enum logic [1:0] {WAIT_MAP, PREFETCH, IDLE} state_t;
    state_t state, state_next;

    logic [9:0]  prev_x;
    logic [6:0]  rd_col;
    logic        wr_en_p1;
    logic [6:0]  wr_col_p1;
    logic [5:0]  target_row;
    logic        wr_bank;
    logic        active_bank;
    logic        underrun_r;
    logic [2:0]  line_buf [0:1][0:COLS-1];

    logic        hblank_edge, line_start, swap, prefetch_req, last_write;
    logic        run, active_px, rd_bank;
    logic [9:0]  y_next;
    logic [5:0]  next_row;
    logic [2:0]  tile_rd;

    logic        vld_p1, vld_p2;
    logic [2:0]  x_p1, y_p1, tile_p1;
    logic [23:0] rgb_p2;

    function automatic logic [23:0] tile_art(input logic [2:0] tile,
                                             input logic [2:0] x,
                                             input logic [2:0] y);
        case (tile)
            3'd0: tile_art = 24'h208020;
            3'd1: tile_art = ((x == 3'd3 || x == 3'd4) && (y == 3'd6 || y == 3'd7))
                             ? 24'h603010 : 24'h005000;
            3'd2: tile_art = (x[0] & y[0]) ? 24'h40B040 : 24'h208020;
            3'd3: tile_art = (x[1] ^ y[1]) ? 24'h40B040 : 24'h208020;
            3'd4: tile_art = (x == y) ? 24'h40B040 : 24'h208020;
            3'd5: tile_art = (x == 3'd0 || y == 3'd0) ? 24'h505050 : 24'h808080;
            default: tile_art = 24'hFF00FF;
        endcase
    endfunction

`ifdef TILE_RENDER_GRID_EN
    function automatic logic [23:0] grid_shade(input logic [23:0] rgb,
                                               input logic [2:0] x,
                                               input logic [2:0] y);
        if (x == 3'd0 || y == 3'd0)
            grid_shade = {1'b0, rgb[23:17], 1'b0, rgb[15:9], 1'b0, rgb[7:1]};
        else
            grid_shade = rgb;
    endfunction

    function automatic logic [23:0] pixel_colour(input logic [2:0] tile,
                                                 input logic [2:0] x,
                                                 input logic [2:0] y);
        pixel_colour = grid_shade(tile_art(tile, x, y), x, y);
    endfunction
`else
    function automatic logic [23:0] pixel_colour(input logic [2:0] tile,
                                                 input logic [2:0] x,
                                                 input logic [2:0] y);
        pixel_colour = tile_art(tile, x, y);
    endfunction
`endif

    // Scan-position events, qualified by the previous DrawX sample.
    assign hblank_edge  = (DrawX == H_ACTIVE) && (prev_x != H_ACTIVE);
    assign line_start   = (DrawX == 10'd0) && (prev_x != 10'd0) &&
                          (DrawY < V_ACTIVE) && (DrawY[2:0] == 3'd0);
    assign swap         = line_start && (state != WAIT_MAP);
    assign prefetch_req = hblank_edge &&
                          (((DrawY < LAST_ROW) && (DrawY[2:0] == 3'd7)) ||
                           (DrawY == LAST_LINE));
    assign y_next       = DrawY + 10'd1;
    assign next_row     = (DrawY == LAST_LINE) ? 6'd0 : y_next[8:3];
    assign last_write   = wr_en_p1 && (wr_col_p1 == LAST_COL);
    assign run          = Gen_Done && (state != WAIT_MAP);
    assign active_px    = (DrawX < H_ACTIVE) && (DrawY < V_ACTIVE);
    // The first pixel of a new tile row must already see the swapped bank.
    assign rd_bank      = swap ? ~active_bank : active_bank;
    assign tile_rd      = (DrawX < H_ACTIVE) ? line_buf[rd_bank][DrawX[9:3]] : 3'd0;

    // FSM: state register
    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) state <= WAIT_MAP;
        else         state <= state_next;
    end

    // FSM: next state
    always_comb begin
        state_next = state;
        case (state)
            WAIT_MAP: if (Gen_Done) state_next = PREFETCH;
            PREFETCH: if (!Gen_Done)     state_next = WAIT_MAP;
                      else if (last_write) state_next = IDLE;
            IDLE:     if (!Gen_Done)     state_next = WAIT_MAP;
                      else if (prefetch_req) state_next = PREFETCH;
            default:  state_next = WAIT_MAP;
        endcase
    end

    // FSM: outputs (Gen_Done gating stops reads in the very Clk it falls)
    always_comb begin
        MapRd  = (state == PREFETCH) && Gen_Done && (rd_col < COLS);
        MapCol = rd_col;
        MapRow = target_row;
    end

    // Control, bank bookkeeping and the reset-visible pixel outputs
    always_ff @(posedge Clk or posedge Reset_h) begin
        if (Reset_h) begin
            prev_x      <= 10'd0;
            rd_col      <= 7'd0;
            wr_en_p1    <= 1'b0;
            target_row  <= 6'd0;
            wr_bank     <= 1'b0;
            active_bank <= 1'b0;
            underrun_r  <= 1'b0;
            vld_p1      <= 1'b0;
            vld_p2      <= 1'b0;
            rgb_p2      <= 24'd0;
        end else begin
            prev_x   <= DrawX;
            wr_en_p1 <= MapRd;
            if (state != PREFETCH || state_next != PREFETCH)
                rd_col <= 7'd0;
            else if (MapRd)
                rd_col <= rd_col + 7'd1;

            if (state == WAIT_MAP && Gen_Done) begin
                // Park on bank 1 so the first swap lands on freshly written bank 0.
                target_row  <= 6'd0;
                wr_bank     <= 1'b0;
                active_bank <= 1'b1;
            end else begin
                if (state == IDLE && Gen_Done && prefetch_req) begin
                    target_row <= next_row;
                    wr_bank    <= ~active_bank;
                end
                if (swap) begin
                    active_bank <= ~active_bank;
                    if (state == PREFETCH) underrun_r <= 1'b1;
                end
            end

            // S1 -> S2 boundary
            vld_p1 <= run && active_px;
            vld_p2 <= run && vld_p1;
            rgb_p2 <= (run && vld_p1) ? pixel_colour(tile_p1, x_p1, y_p1) : 24'd0;
        end
    end

    // Data path: line buffer write and S1 pixel registers
    always_ff @(posedge Clk) begin
        if (wr_en_p1) line_buf[wr_bank][wr_col_p1] <= tilenumber;
        wr_col_p1 <= MapCol;
        x_p1      <= DrawX[2:0];
        y_p1      <= DrawY[2:0];
        tile_p1   <= tile_rd;
    end

    assign Red         = rgb_p2[23:16];
    assign Green       = rgb_p2[15:8];
    assign Blue        = rgb_p2[7:0];
    assign Pixel_Valid = vld_p2;
    assign Underrun    = underrun_r;

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer: a stub tile map answers the read port,
// scan positions are driven directly and each output is compared against
// hand-computed colours and read counts.
module tb_tile_renderer;

    logic       Clk, Reset_h, Gen_Done;
    logic [9:0] DrawX, DrawY;
    logic       MapRd;
    logic [6:0] MapCol;
    logic [5:0] MapRow;
    logic [2:0] tilenumber;
    logic [7:0] Red, Green, Blue;
    logic       Pixel_Valid, Underrun;

    int checks = 0;
    int errors = 0;

    // stub map state
    int tot_rd   = 0;
    int seq_err  = 0;
    int run_base = 0;
    int exp_row  = 0;
    bit map_five = 0;

    tile_renderer dut (
        .Clk(Clk), .Reset_h(Reset_h), .Gen_Done(Gen_Done),
        .DrawX(DrawX), .DrawY(DrawY),
        .MapRd(MapRd), .MapCol(MapCol), .MapRow(MapRow),
        .tilenumber(tilenumber),
        .Red(Red), .Green(Green), .Blue(Blue),
        .Pixel_Valid(Pixel_Valid), .Underrun(Underrun)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial tilenumber = 3'd0;
    always @(posedge Clk) begin
        if (MapRd) begin
            if (int'(MapCol) != tot_rd - run_base || int'(MapRow) != exp_row)
                seq_err <= seq_err + 1;
            tot_rd     <= tot_rd + 1;
            tilenumber <= map_five ? 3'd5 : 3'(MapCol + {1'b0, MapRow});
        end
    end

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic pix(input int x, input int y, input logic [23:0] rgb, input bit vld);
        logic [23:0] e;
        e = vld ? rgb : 24'd0;
`ifdef TILE_RENDER_GRID_EN
        if (vld && (x % 8 == 0 || y % 8 == 0))
            e = {1'b0, e[23:17], 1'b0, e[15:9], 1'b0, e[7:1]};
`endif
        @(negedge Clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        @(posedge Clk);
        @(posedge Clk);
        #1;
        check($sformatf("rgb(%0d,%0d)", x, y), int'({Red, Green, Blue}), int'(e));
        check($sformatf("vld(%0d,%0d)", x, y), int'(Pixel_Valid), int'(vld));
    endtask

    // Creates a hblank edge on line y.
    task automatic hb(input int y);
        @(negedge Clk);
        DrawX = 10'd700;
        DrawY = 10'(y);
        @(negedge Clk);
        DrawX = 10'd640;
    endtask

    task automatic arm(input int row);
        exp_row  = row;
        run_base = tot_rd;
    endtask

    initial begin
        int sb;
        bit found;
        Reset_h  = 1'b1;
        Gen_Done = 1'b0;
        DrawX    = 10'd700;
        DrawY    = 10'd0;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_maprd", int'(MapRd), 0);
        check("rst_mapcol", int'(MapCol), 0);
        check("rst_maprow", int'(MapRow), 0);
        check("rst_rgb", int'({Red, Green, Blue}), 0);
        check("rst_vld", int'(Pixel_Valid), 0);
        check("rst_underrun", int'(Underrun), 0);
        @(negedge Clk);
        Reset_h = 1'b0;

        // initial row-0 prefetch, map = (col+row)%8
        sb = seq_err;
        arm(0);
        @(negedge Clk);
        Gen_Done = 1'b1;
        repeat (100) @(negedge Clk);
        check("init_reads", tot_rd - run_base, 80);
        check("init_seq", seq_err - sb, 0);
        check("init_idle_maprd", int'(MapRd), 0);
        check("init_underrun", int'(Underrun), 0);

        pix(0, 0, 24'h208020, 1);     // swap onto row 0, tile 0
        pix(11, 6, 24'h603010, 1);    // tile 1 trunk
        pix(9, 1, 24'h005000, 1);     // tile 1 canopy
        pix(17, 1, 24'h40B040, 1);    // tile 2 dot
        pix(25, 1, 24'h208020, 1);    // tile 3 base
        pix(26, 1, 24'h40B040, 1);    // tile 3 stripe
        pix(34, 2, 24'h40B040, 1);    // tile 4 diagonal
        pix(40, 3, 24'h505050, 1);    // tile 5 mortar
        pix(41, 3, 24'h808080, 1);    // tile 5 face
        pix(49, 1, 24'hFF00FF, 1);    // tile 6
        pix(57, 1, 24'hFF00FF, 1);    // tile 7
        pix(1, 1, 24'h208020, 1);     // tile 0 interior

        // two-Clk latency
        @(negedge Clk); DrawX = 10'd700; DrawY = 10'd1;
        @(posedge Clk);
        @(negedge Clk); DrawX = 10'd41;  DrawY = 10'd3;
        @(posedge Clk); #1;
        check("lat_one_clk_vld", int'(Pixel_Valid), 0);
        @(negedge Clk); DrawX = 10'd640;
        @(posedge Clk); #1;
        check("lat_two_clk_rgb", int'({Red, Green, Blue}), 24'h808080);
        check("lat_two_clk_vld", int'(Pixel_Valid), 1);
        @(posedge Clk); #1;
        check("lat_hblank_vld", int'(Pixel_Valid), 0);

        // row 1 prefetch at line 7, swap at line 8
        sb = seq_err;
        arm(1);
        hb(7);
        repeat (100) @(negedge Clk);
        check("row1_reads", tot_rd - run_base, 80);
        check("row1_seq", seq_err - sb, 0);
        pix(0, 8, 24'h005000, 1);     // row 1 col 0 -> tile 1
        pix(9, 9, 24'h40B040, 1);     // row 1 col 1 -> tile 2

        // all-stone map, row 2
        map_five = 1'b1;
        sb = seq_err;
        arm(2);
        hb(15);
        repeat (100) @(negedge Clk);
        check("row2_reads", tot_rd - run_base, 80);
        pix(0, 16, 24'h505050, 1);
        pix(9, 17, 24'h808080, 1);
        pix(640, 17, 24'h000000, 0);

        // last line of frame prefetches row 0
        arm(0);
        hb(524);
        repeat (100) @(negedge Clk);
        check("wrap_reads", tot_rd - run_base, 80);
        check("wrap_seq", seq_err - sb, 0);
        check("pre_underrun", int'(Underrun), 0);

        // swap forced in the middle of a prefetch
        arm(3);
        hb(23);
        repeat (20) @(negedge Clk);
        DrawX = 10'd0;
        DrawY = 10'd24;
        @(posedge Clk); #1;
        check("underrun_set", int'(Underrun), 1);
        repeat (100) @(negedge Clk);
        check("underrun_reads", tot_rd - run_base, 80);
        check("underrun_sticky", int'(Underrun), 1);

        // abort at column 40
        arm(4);
        hb(31);
        found = 1'b0;
        for (int i = 0; i < 120; i++) begin
            @(negedge Clk);
            if (MapRd && MapCol == 7'd40) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_reached_col40", int'(found), 1);
        Gen_Done = 1'b0;
        DrawX    = 10'd100;
        DrawY    = 10'd33;
        @(posedge Clk); #1;
        check("abort_maprd", int'(MapRd), 0);
        check("abort_reads", tot_rd - run_base, 40);
        @(posedge Clk); #1;
        check("abort_vld", int'(Pixel_Valid), 0);
        check("abort_rgb", int'({Red, Green, Blue}), 0);

        // restart from column 0 of row 0
        sb = seq_err;
        arm(0);
        @(negedge Clk);
        Gen_Done = 1'b1;
        repeat (100) @(negedge Clk);
        check("restart_reads", tot_rd - run_base, 80);
        check("restart_seq", seq_err - sb, 0);
        check("restart_underrun", int'(Underrun), 1);

        // asynchronous reset clears the sticky flag without a clock edge
        @(negedge Clk);
        Reset_h = 1'b1;
        #1;
        check("reset_underrun", int'(Underrun), 0);
        check("reset_maprd", int'(MapRd), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_renderer.md
# tile_renderer

Reads the generated 80×60 background tile map and turns it into per-pixel RGB for the VGA datapath. Prefetches one tile row (80 tile numbers) into a ping-pong line buffer during horizontal blank, then renders procedural 8×8 tile art from the buffered tile numbers. Sits between the background map generator (tile-map writer) and the colour mapper, driving the map's row/column read port.

## Interface
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- V_TOTAL, 525, total lines per frame
- COLS, 80, tiles per row (H_ACTIVE/8)
- ROWS, 60, tile rows (V_ACTIVE/8)
- Clk  in  1  system clock; single clock domain
- Reset_h  in  1  asynchronous, active-high reset
- Gen_Done  in  1  map generation complete; map contents valid while high
- DrawX, DrawY  in  10 each  current VGA scan position; may change at most once per Clk
- MapRd  out  1  map read strobe
- MapCol  out  7  tile column being read
- MapRow  out  6  tile row being read
- tilenumber  in  3  map data; valid the Clk after MapRd
- Red, Green, Blue  out  8 each  pixel colour
- Pixel_Valid  out  1  RGB corresponds to an active-area pixel
- Underrun  out  1  sticky: a bank swap occurred before its prefetch finished

## Operation
- FSM states: WAIT_MAP, PREFETCH, IDLE.
- WAIT_MAP: MapRd=0; RGB=0, Pixel_Valid=0. On Gen_Done high: target row 0, write bank 0, go to PREFETCH.
- PREFETCH: issue MapRd with MapCol 0..79 on consecutive Clks, MapRow=target row; write returned tilenumber into the write bank, entry MapCol, one Clk later. Done after the 80th write. Then go to IDLE.
- IDLE: on a hblank edge, meaning DrawX becomes H_ACTIVE (DrawX==640 and the previous sample was not 640), compute next row:
  - DrawY in 0..479 with DrawY[2:0]==7 and DrawY<479: prefetch row (DrawY+1)>>3 into the inactive bank.
  - DrawY==V_TOTAL-1 (524): prefetch row 0 into the inactive bank.
  - Otherwise stay in IDLE.
- Gen_Done falling in any state: abort immediately, MapRd=0, go to WAIT_MAP. The line buffer is not cleared.
- Bank swap: on the Clk where DrawX becomes 0 with DrawY<480 and DrawY[2:0]==0, the active bank toggles.
  - If the FSM is in PREFETCH at that Clk, set Underrun and still swap.
  - The first swap after WAIT_MAP→PREFETCH selects bank 0.
- Pixel path, 2-stage pipeline:
  - S1 registers DrawX, DrawY and tile = active_bank[DrawX>>3].
  - S2 registers RGB from tile, x=DrawX[2:0], y=DrawY[2:0].
- Tile art, RGB in hex:
  - 0: 20/80/20.
  - 1 (tree): 00/50/00; trunk 60/30/10 where x∈{3,4} and y∈{6,7}.
  - 2: 20/80/20; 40/B0/40 where x[0]&y[0].
  - 3: 20/80/20; 40/B0/40 where x[1]^y[1].
  - 4: 20/80/20; 40/B0/40 where x==y.
  - 5 (stone): 80/80/80; 50/50/50 where x==0 or y==0.
  - 6, 7: FF/00/FF.
- Outside the active area (DrawX≥640 or DrawY≥480) or while in WAIT_MAP: RGB=0, Pixel_Valid=0.

## Timing
- Reset (asynchronous): state WAIT_MAP; MapRd, MapCol, MapRow, RGB, Pixel_Valid, Underrun all 0; active bank 0.
- Pixel latency: RGB and Pixel_Valid reflect the DrawX/DrawY sampled 2 Clks earlier.
- Prefetch occupancy: 81 Clks from the first MapRd to the last buffer write. This fits in the 160-pixel hblank at any pixel rate ≤ Clk.
- Initial row 0 prefetch completes 81 Clks after Gen_Done rises; frames rendered before that completes may set Underrun.
- Hblank edges arriving during PREFETCH are ignored.
- Reset asserted mid-prefetch: abort within the same Clk (asynchronous).

## Configuration
- TILE_RENDER_GRID_EN defined: any active pixel with x==0 or y==0 has each colour channel halved (logical shift right 1) after tile art is applied. This adds no latency.
- Not defined: tile art is output unmodified.

## Test plan
- Reset, then Gen_Done=1 with a stub map returning tilenumber=(col+row)%8: exactly 80 MapRd pulses with MapRow=0, MapCol 0..79, then IDLE; Underrun=0.
- Full 800×525 frame scan, stub map returns 5 everywhere: pixel (8,8) → 50/50/50, pixel (9,9) → 80/80/80, Pixel_Valid low at DrawX=640; output lags the scan by exactly 2 Clks.
- Hblank edge at DrawY=7: prefetch of row 1; at DrawX=0, DrawY=8 banks swap and tile column 0 shows the row-1 data. At DrawY=524: row 0 is prefetched.
- Stub map stalls Gen_Done high but forces a swap mid-prefetch (a short hblank stimulus): Underrun=1 and stays 1 until Reset_h.
- Gen_Done drops at MapCol=40: MapRd deasserts the next Clk, RGB=0, Pixel_Valid=0; re-raising Gen_Done restarts a row-0 prefetch from MapCol=0.
- With TILE_RENDER_GRID_EN defined, tile 0 at x=0: output 10/40/10; at x=1, y=1: 20/80/20.
